// File: rtl/bcd_seq_pkg.sv
// Shared types and seven-segment constants for the BCD add sequencer.
// Segment codes are active-low, bit order g f e d c b a.
package bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Non-BCD codes cannot reach the accumulator; they decode to blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] code;
        if (digit <= BCD_MAX) begin
            code = SEG_DIGIT[digit];
        end else begin
            code = SEG_BLANK;
        end
        return code;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal carry; purely combinational.
module bcd_digit_add
    import bcd_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw_s;

    assign raw_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

    // Subtracting 10 equals adding 6 modulo 16 for the low nibble.
    always_comb begin
        sum  = raw_s[3:0];
        cout = 1'b0;
        if (raw_s > {1'b0, BCD_MAX}) begin
            sum  = raw_s[3:0] + 4'd6;
            cout = 1'b1;
        end else begin
            sum  = raw_s[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_add_sequencer.sv
// Push-button decimal accumulator: one shared BCD digit adder walks the
// accumulator one digit per clock; the display decodes only committed values.
module bcd_add_sequencer
    import bcd_seq_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [3:0]              SW,
    input  logic                    KEY_ADD,
    input  logic                    KEY_CLR,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic                    BUSY,
    output logic                    OVF,
    output logic                    ERR
);

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam int               BTN_ADD  = 0;
    localparam int               BTN_CLR  = 1;

    logic [1:0] key_s;
    logic [1:0] press_s;

    assign key_s = {KEY_CLR, KEY_ADD};

    // A press counts only after the button has been seen released since reset,
    // so a key held through reset release never fires.
    for (genvar btn = 0; btn < 2; btn++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_r;
        logic [SYNC_STAGES-1:0] valid_r;
        logic                   hist_r;
        logic                   armed_r;
        logic                   pulse_r;

        // Synchronizer chain, falling-edge detect and registered press pulse.
        always_ff @(posedge CLOCK_50) begin
            if (!RESET_N) begin
                sync_r  <= {SYNC_STAGES{1'b1}};
                valid_r <= {SYNC_STAGES{1'b0}};
                hist_r  <= 1'b1;
                armed_r <= 1'b0;
                pulse_r <= 1'b0;
            end else begin
                sync_r  <= {sync_r[SYNC_STAGES-2:0], key_s[btn]};
                valid_r <= {valid_r[SYNC_STAGES-2:0], 1'b1};
                hist_r  <= sync_r[SYNC_STAGES-1];
                if (valid_r[SYNC_STAGES-1] && sync_r[SYNC_STAGES-1]) begin
                    armed_r <= 1'b1;
                end else begin
                    armed_r <= armed_r;
                end
                pulse_r <= armed_r & hist_r & ~sync_r[SYNC_STAGES-1];
            end
        end

        assign press_s[btn] = pulse_r;
    end

    state_t                        state_r;
    logic [NUM_DIGITS-1:0][3:0]    acc_r;
    logic [NUM_DIGITS-1:0][3:0]    work_r;
    logic [IDX_W-1:0]              idx_r;
    logic [3:0]                    operand_r;
    logic                          carry_r;
    logic                          busy_r;
    logic                          ovf_r;
    logic                          err_r;

    logic [3:0] add_a_s;
    logic [3:0] add_b_s;
    logic [3:0] add_sum_s;
    logic       add_cout_s;

    // Operand is injected only at the least significant digit; higher digits ripple carry.
    always_comb begin
        add_a_s = work_r[idx_r];
        if (idx_r == {IDX_W{1'b0}}) begin
            add_b_s = operand_r;
        end else begin
            add_b_s = 4'd0;
        end
    end

    bcd_digit_add u_digit_add (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (carry_r),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Sequencer: accept, walk digits, commit or saturate.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_r   <= IDLE;
            acc_r     <= {NUM_DIGITS{4'd0}};
            work_r    <= {NUM_DIGITS{4'd0}};
            idx_r     <= {IDX_W{1'b0}};
            operand_r <= 4'd0;
            carry_r   <= 1'b0;
            busy_r    <= 1'b0;
            ovf_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (press_s[BTN_CLR]) begin
                        acc_r <= {NUM_DIGITS{4'd0}};
                        ovf_r <= 1'b0;
                        err_r <= 1'b0;
                    end else if (press_s[BTN_ADD]) begin
                        if (SW > BCD_MAX) begin
                            err_r <= 1'b1;
                        end else begin
                            err_r     <= 1'b0;
                            operand_r <= SW;
                            work_r    <= acc_r;
                            idx_r     <= {IDX_W{1'b0}};
                            carry_r   <= 1'b0;
                            busy_r    <= 1'b1;
                            state_r   <= ADD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADD: begin
                    work_r[idx_r] <= add_sum_s;
                    carry_r       <= add_cout_s;
                    if (idx_r == IDX_LAST) begin
                        idx_r   <= {IDX_W{1'b0}};
                        state_r <= COMMIT;
                    end else begin
                        idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                COMMIT: begin
                    if (carry_r) begin
                        acc_r <= {NUM_DIGITS{BCD_MAX}};
                        ovf_r <= 1'b1;
                    end else begin
                        acc_r <= work_r;
                    end
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_r;
    assign OVF  = ovf_r;
    assign ERR  = err_r;

    // upper_zero_s[i]: digits i..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS:1] upper_zero_s;

    assign upper_zero_s[NUM_DIGITS] = 1'b1;
    for (genvar d = 1; d < NUM_DIGITS; d++) begin : g_lz
        assign upper_zero_s[d] = upper_zero_s[d+1] & (acc_r[d] == 4'd0);
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_disp
        logic [6:0] seg_r;

        if (d == 0) begin : g_lsd
            // Least significant display always shows its digit.
            always_ff @(posedge CLOCK_50) begin
                if (!RESET_N) begin
                    seg_r <= SEG_DIGIT[0];
                end else begin
                    seg_r <= seg_decode(acc_r[d]);
                end
            end
        end else begin : g_upper
            // Higher displays blank while they and everything above are zero.
            always_ff @(posedge CLOCK_50) begin
                if (!RESET_N) begin
                    seg_r <= SEG_BLANK;
                end else if (upper_zero_s[d]) begin
                    seg_r <= SEG_BLANK;
                end else begin
                    seg_r <= seg_decode(acc_r[d]);
                end
            end
        end

        assign HEX[7*d +: 7] = seg_r;
    end

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// Table-driven bench with an expectation queue for the two-digit BCD add sequencer.
module tb_bcd_add_sequencer;

    localparam int ND = 2;
    localparam int SS = 2;
    localparam int OP_ADD  = 0;
    localparam int OP_CLR  = 1;
    localparam int OP_BOTH = 2;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [3:0]    sw      = 4'd0;
    logic          key_add = 1'b1;
    logic          key_clr = 1'b1;
    logic [7*ND-1:0] hex;
    logic          busy;
    logic          ovf;
    logic          err;

    always #5 clk = ~clk;

    bcd_add_sequencer #(.NUM_DIGITS(ND), .SYNC_STAGES(SS)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .SW       (sw),
        .KEY_ADD  (key_add),
        .KEY_CLR  (key_clr),
        .HEX      (hex),
        .BUSY     (busy),
        .OVF      (ovf),
        .ERR      (err)
    );

    typedef struct {
        int         op;
        logic [3:0] sw;
        int         val;
        int         busy;
        logic       ovf;
        logic       err;
    } vec_t;

    typedef struct {
        int   val;
        int   busy;
        logic ovf;
        logic err;
    } exp_t;

    exp_t       sbq[$];
    vec_t       vecs[$];
    logic [6:0] seg_tab [0:9];
    int         pass_cnt  = 0;
    int         total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] exp_hex(input int v);
        int d0;
        int d1;
        logic [6:0] hi;
        d0 = v % 10;
        d1 = (v / 10) % 10;
        hi = (d1 == 0) ? 7'h7F : seg_tab[d1];
        return {hi, seg_tab[d0]};
    endfunction

    // Compare DUT outputs against the oldest queued expectation.
    task automatic score(input string name, input int bcnt, input int first);
        exp_t e;
        if (sbq.size() == 0) begin
            check({name, " queue"}, 0, 1);
        end else begin
            e = sbq.pop_front();
            check({name, " hex"},  int'(hex), int'(exp_hex(e.val)));
            check({name, " busy"}, bcnt, e.busy);
            check({name, " ovf"},  int'(ovf), int'(e.ovf));
            check({name, " err"},  int'(err), int'(e.err));
            if (e.busy > 0) check({name, " lat"}, first, SS + 2);
        end
    endtask

    task automatic do_op(input string name, input int op, input logic [3:0] s,
                         input int val, input int bexp, input logic o, input logic e);
        exp_t x;
        int bcnt;
        int first;
        x = '{val, bexp, o, e};
        sbq.push_back(x);
        sw = s;
        bcnt = 0;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                bcnt++;
                if (first < 0) first = i;
            end
            key_add = !((op == OP_ADD || op == OP_BOTH) && i < 6);
            key_clr = !((op == OP_CLR || op == OP_BOTH) && i < 6);
        end
        score(name, bcnt, first);
    endtask

    initial begin
        exp_t x;
        int   bcnt;
        int   first;
        int   late_busy;

        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

        // Reset held for three clocks.
        repeat (3) @(negedge clk);
        check("rst hex", int'(hex), int'(14'h3FC0));
        check("rst busy", int'(busy), 0);
        check("rst ovf", int'(ovf), 0);
        check("rst err", int'(err), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("idle hex", int'(hex), int'(exp_hex(0)));

        vecs.push_back('{OP_CLR, 4'd0,  0,  0, 1'b0, 1'b0});
        vecs.push_back('{OP_ADD, 4'd7,  7,  3, 1'b0, 1'b0});
        vecs.push_back('{OP_ADD, 4'd7,  14, 3, 1'b0, 1'b0});
        vecs.push_back('{OP_ADD, 4'd12, 14, 0, 1'b0, 1'b1});
        vecs.push_back('{OP_ADD, 4'd1,  15, 3, 1'b0, 1'b0});
        vecs.push_back('{OP_ADD, 4'd15, 15, 0, 1'b0, 1'b1});
        vecs.push_back('{OP_ADD, 4'd10, 15, 0, 1'b0, 1'b1});
        vecs.push_back('{OP_ADD, 4'd9,  24, 3, 1'b0, 1'b0});
        vecs.push_back('{OP_ADD, 4'd0,  24, 3, 1'b0, 1'b0});
        vecs.push_back('{OP_ADD, 4'd6,  30, 3, 1'b0, 1'b0});
        vecs.push_back('{OP_CLR, 4'd0,  0,  0, 1'b0, 1'b0});
        for (int k = 1; k <= 10; k++) vecs.push_back('{OP_ADD, 4'd9, 9 * k, 3, 1'b0, 1'b0});
        vecs.push_back('{OP_ADD, 4'd5,  95, 3, 1'b0, 1'b0});
        vecs.push_back('{OP_ADD, 4'd9,  99, 3, 1'b1, 1'b0});
        vecs.push_back('{OP_ADD, 4'd0,  99, 3, 1'b1, 1'b0});
        vecs.push_back('{OP_ADD, 4'd1,  99, 3, 1'b1, 1'b0});
        vecs.push_back('{OP_ADD, 4'd11, 99, 0, 1'b1, 1'b1});
        vecs.push_back('{OP_CLR, 4'd0,  0,  0, 1'b0, 1'b0});

        foreach (vecs[n]) begin
            do_op($sformatf("vec%0d", n), vecs[n].op, vecs[n].sw, vecs[n].val,
                  vecs[n].busy, vecs[n].ovf, vecs[n].err);
        end

        // Build acc=42, then clear and add fall together: clear wins.
        for (int k = 1; k <= 4; k++) do_op("to42", OP_ADD, 4'd9, 9 * k, 3, 1'b0, 1'b0);
        do_op("to42", OP_ADD, 4'd6, 42, 3, 1'b0, 1'b0);
        do_op("both", OP_BOTH, 4'd5, 0, 0, 1'b0, 1'b0);

        // Second add press lands while busy and must be dropped.
        x = '{3, 3, 1'b0, 1'b0};
        sbq.push_back(x);
        sw = 4'd3;
        bcnt = 0;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                bcnt++;
                if (first < 0) first = i;
            end
            key_add = !(i == 0 || i == 2);
        end
        score("drop", bcnt, first);

        // Reset during ADD with the add key held through reset release.
        do_op("pre8", OP_CLR, 4'd0, 0, 0, 1'b0, 1'b0);
        do_op("pre8", OP_ADD, 4'd8, 8, 3, 1'b0, 1'b0);
        sw = 4'd5;
        late_busy = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 4) begin
                check("mid busy", int'(busy), 1);
                rst_n = 1'b0;
            end
            if (i == 5) begin
                check("mid rst busy", int'(busy), 0);
                check("mid rst hex", int'(hex), int'(14'h3FC0));
                check("mid rst ovf", int'(ovf), 0);
            end
            if (i == 7) rst_n = 1'b1;
            if (i >= 5 && busy) late_busy++;
            key_add = 1'b0;
        end
        check("held no pulse", late_busy, 0);
        check("held hex", int'(hex), int'(exp_hex(0)));
        key_add = 1'b1;
        repeat (5) @(negedge clk);
        do_op("repress", OP_ADD, 4'd5, 5, 3, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
